// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: fully pipelined multiplier plus radix-2 restoring divider FSM.
// Optional feature macro: MULDIV_EARLY_OUT_EN (|a| < |b| divides bypass the iteration loop).
module muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2,
    parameter int TAG_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             out_valid,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_rd,
    output logic             busy
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [XLEN-1:0]  quo_q, rem_q, dvsr_q;
    logic             neg_quo_q, neg_rem_q, is_rem_q;
    logic [TAG_W-1:0] div_tag_q;
    logic             out_valid_q;
    logic [XLEN-1:0]  out_result_q;
    logic [TAG_W-1:0] out_rd_q;

    logic             accept, mul_acc, div_acc;
    logic             pipe_busy, div_done;
    logic [XLEN-1:0]  div_res;

    assign accept  = in_valid & in_ready;
    assign mul_acc = accept & ~op[2];
    assign div_acc = accept & op[2];

    // Full 2*XLEN product from sign/zero-extended operands; low half for MUL, high half otherwise.
    logic              a_sext, b_sext;
    logic [2*XLEN-1:0] a_ext, b_ext, prod;
    logic [XLEN-1:0]   mul_res;

    assign a_sext  = (op[1:0] != 2'd3);
    assign b_sext  = ~op[1];
    assign a_ext   = {{XLEN{a_sext & a[XLEN-1]}}, a};
    assign b_ext   = {{XLEN{b_sext & b[XLEN-1]}}, b};
    assign prod    = a_ext * b_ext;
    assign mul_res = (op[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    logic             tail_vld;
    logic [XLEN-1:0]  tail_res;
    logic [TAG_W-1:0] tail_tag;

    generate
        if (MUL_STAGES == 1) begin : g_nopipe
            assign tail_vld  = mul_acc;
            assign tail_res  = mul_res;
            assign tail_tag  = rd_tag;
            assign pipe_busy = 1'b0;
        end else begin : g_pipe
            logic [MUL_STAGES-2:0] vld_q;
            logic [XLEN-1:0]       res_q [MUL_STAGES-1];
            logic [TAG_W-1:0]      tag_q [MUL_STAGES-1];

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    vld_q <= '0;
                end else begin
                    vld_q[0] <= mul_acc;
                    for (int k = 1; k < MUL_STAGES - 1; k++) begin
                        vld_q[k] <= vld_q[k-1];
                    end
                end
                res_q[0] <= mul_res;
                tag_q[0] <= rd_tag;
                for (int k = 1; k < MUL_STAGES - 1; k++) begin
                    res_q[k] <= res_q[k-1];
                    tag_q[k] <= tag_q[k-1];
                end
            end

            assign tail_vld  = vld_q[MUL_STAGES-2];
            assign tail_res  = res_q[MUL_STAGES-2];
            assign tail_tag  = tag_q[MUL_STAGES-2];
            assign pipe_busy = |vld_q;
        end
    endgenerate

    logic            div_signed, a_neg, b_neg, b_zero, ovf, early, fast;
    logic [XLEN-1:0] mag_a, mag_b;

    assign div_signed = ~op[0];
    assign a_neg      = div_signed & a[XLEN-1];
    assign b_neg      = div_signed & b[XLEN-1];
    assign mag_a      = a_neg ? (~a + 1'b1) : a;
    assign mag_b      = b_neg ? (~b + 1'b1) : b;
    assign b_zero     = (b == '0);
    assign ovf        = div_signed & (a == MOST_NEG) & (b == '1);
`ifdef MULDIV_EARLY_OUT_EN
    assign early      = (mag_a < mag_b);
`else
    assign early      = 1'b0;
`endif
    assign fast       = b_zero | ovf | early;

    // One restoring step: shift next dividend bit into the partial remainder, subtract if it fits.
    logic [XLEN:0] rem_sh, diff;
    assign rem_sh = {rem_q, quo_q[XLEN-1]};
    assign diff   = rem_sh - {1'b0, dvsr_q};

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (div_acc) state_d = fast ? DONE : RUN;
            RUN:  if (cnt_q == CW'(1)) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = ~flush & ~rst & (state_q == IDLE) & (~op[2] | ~pipe_busy);
        busy     = pipe_busy | (state_q != IDLE);
        div_done = (state_q == DONE);
        if (is_rem_q) begin
            div_res = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
        end else begin
            div_res = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            cnt_q <= '0;
        end else if (state_q == IDLE && div_acc) begin
            div_tag_q <= rd_tag;
            is_rem_q  <= op[1];
            dvsr_q    <= mag_b;
            if (b_zero) begin
                quo_q     <= '1;
                rem_q     <= a;
                neg_quo_q <= 1'b0;
                neg_rem_q <= 1'b0;
            end else if (ovf) begin
                quo_q     <= a;
                rem_q     <= '0;
                neg_quo_q <= 1'b0;
                neg_rem_q <= 1'b0;
            end else if (early) begin
                quo_q     <= '0;
                rem_q     <= mag_a;
                neg_quo_q <= 1'b0;
                neg_rem_q <= a_neg;
            end else begin
                quo_q     <= mag_a;
                rem_q     <= '0;
                cnt_q     <= CW'(XLEN);
                neg_quo_q <= a_neg ^ b_neg;
                neg_rem_q <= a_neg;
            end
        end else if (state_q == RUN) begin
            cnt_q <= cnt_q - 1'b1;
            if (!diff[XLEN]) begin
                rem_q <= diff[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_q <= rem_sh[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end
        end
    end

    // Mul and div results never coincide because in_ready keeps the two paths exclusive.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_rd_q     <= '0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
        end else if (tail_vld) begin
            out_valid_q  <= 1'b1;
            out_result_q <= tail_res;
            out_rd_q     <= tail_tag;
        end else if (div_done) begin
            out_valid_q  <= 1'b1;
            out_result_q <= div_res;
            out_rd_q     <= div_tag_q;
        end else begin
            out_valid_q  <= 1'b0;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_rd     = out_rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed corner cases plus randomized ops vs an arithmetic model.
module tb_muldiv_unit;
    localparam int XLEN       = 32;
    localparam int MUL_STAGES = 2;
    localparam int TAG_W      = 5;

    logic             clk = 1'b0;
    logic             rst, flush, in_valid, in_ready;
    logic [2:0]       op;
    logic [XLEN-1:0]  a, b;
    logic [TAG_W-1:0] rd_tag;
    logic             out_valid, busy;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_rd;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [XLEN-1:0]  res;
        logic [TAG_W-1:0] tag;
        int               due;
    } exp_t;
    exp_t sbq[$];

    muldiv_unit #(.XLEN(XLEN), .MUL_STAGES(MUL_STAGES), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .rd_tag(rd_tag), .out_valid(out_valid),
        .out_result(out_result), .out_rd(out_rd), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference arithmetic straight from the RV32M definitions using 64-bit integers.
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, ux, uy, q;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        case (o)
            3'd0: begin p = sx * sy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
                q = sx / sy; return q[31:0];
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
                q = sx % sy; return q[31:0];
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] mx, my;
        mx = (!o[0] && x[31]) ? -x : x;
        my = (!o[0] && y[31]) ? -y : y;
        if (!o[2]) return MUL_STAGES;
        if (y == 0) return 2;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 2;
`ifdef MULDIV_EARLY_OUT_EN
        if (mx < my) return 2;
`else
        if (mx < my) return XLEN + 2;
`endif
        return XLEN + 2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("check %s: %h ok", name, act);
        end
    endtask

    // Present an op (called #1 after a rising edge) and hold it until accepted.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] t, input bit want, output int acc);
        exp_t e;
        in_valid = 1'b1; op = o; a = x; b = y; rd_tag = t;
        acc = -1;
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = cyc;
                if (want) begin
                    e.res = model(o, x, y);
                    e.tag = t;
                    e.due = cyc + lat(o, x, y);
                    sbq.push_back(e);
                end
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        checks++; errors++;
        $display("FAIL issue_timeout: op %0d never accepted, got in_ready=0 expected 1", o);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int w = 0; w < 200 && !done; w++) begin
            @(negedge clk);
            if (sbq.size() == 0 && !busy) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain: got %0d pending results expected 0", sbq.size());
        end
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (out_valid) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got out_valid with %h tag %0d expected none", out_result, out_rd);
            end else begin
                e = sbq.pop_front();
                if (out_result !== e.res || out_rd !== e.tag || cyc != e.due) begin
                    errors++;
                    $display("FAIL result: got %h tag %0d cycle %0d expected %h tag %0d cycle %0d",
                             out_result, out_rd, cyc, e.res, e.tag, e.due);
                end else begin
                    $display("result %h tag %0d cycle %0d ok", out_result, out_rd, cyc);
                end
            end
        end
    end

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 20);
            4: return 32'h0 - $urandom_range(1, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int c1, c2, bad;
        logic [2:0] ro;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; op = 3'd0; a = '0; b = '0; rd_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_out_result", out_result, 32'h0);
        chk("rst_out_rd", {27'b0, out_rd}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_in_ready", {31'b0, in_ready}, 32'h1);

        // Back-to-back multiplies.
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1, 1'b1, c1);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b1, c2);
        chk("mul_back_to_back", c2, c1 + 1);
        drain();

        // Full-latency divide: unit stays unready for its whole run.
        issue(3'd4, 32'hFFFF_FFEC, 32'd3, 5'd3, 1'b1, c1);
        bad = 0;
        for (int k = 1; k <= XLEN + 1; k++) begin
            @(negedge clk);
            if (in_ready) bad++;
        end
        @(posedge clk); #1;
        chk("div_in_ready_low", bad, 0);
        drain();
        issue(3'd6, 32'hFFFF_FFEC, 32'd3, 5'd4, 1'b1, c1);
        drain();

        // Special cases.
        issue(3'd5, 32'd5, 32'd0, 5'd5, 1'b1, c1);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 1'b1, c1);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 1'b1, c1);
        issue(3'd7, 32'h1234_5678, 32'd0, 5'd8, 1'b1, c1);
        issue(3'd5, 32'd3, 32'd10, 5'd9, 1'b1, c1);
        drain();

        // Divide must wait for the multiply pipe to empty.
        issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd10, 1'b1, c1);
        issue(3'd4, 32'd100, 32'd7, 5'd11, 1'b1, c2);
        chk("div_waits_for_mul", c2, c1 + MUL_STAGES);
        drain();

        // Flush mid-divide with a multiply presented in the flush cycle.
        issue(3'd4, 32'd1000, 32'd7, 5'd12, 1'b0, c1);
        repeat (4) begin @(posedge clk); #1; end
        flush = 1'b1; in_valid = 1'b1; op = 3'd0; a = 32'd5; b = 32'd6; rd_tag = 5'd13;
        @(negedge clk);
        chk("flush_in_ready", {31'b0, in_ready}, 32'h0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_busy", {31'b0, busy}, 32'h0);
        issue(3'd0, 32'd11, 32'd13, 5'd14, 1'b1, c2);
        chk("mul_after_flush", c2, c1 + 6);
        drain();

        // Reset in the middle of a divide zeroes the outputs.
        issue(3'd5, 32'd999, 32'd4, 5'd15, 1'b0, c1);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midop_rst_result", out_result, 32'h0);
        chk("midop_rst_busy", {31'b0, busy}, 32'h0);
        drain();

        for (int n = 0; n < 300; n++) begin
            ro = 3'($urandom_range(0, 7));
            issue(ro, rand_val(), rand_val(), 5'($urandom_range(0, 31)), 1'b1, c1);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        drain();

        chk("scoreboard_empty", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
